// File: rtl/digital_timer_ctrl_if.sv
// Button, live-digit and timer-control bundle between the board/timer and digital_timer_ctrl.
// The slave modport is the controller side; the master modport drives the buttons and live digits.
interface digital_timer_ctrl_if;
    logic            btn_start_stop;
    logic            btn_lap_reset;
    logic [5:0][6:0] clock_digits;
    logic            timer_pause;
    logic            timer_clear;
    logic            timer_reset;
    logic            lap_hold;
    logic [2:0]      ctrl_state;
    logic [5:0][6:0] disp_digits;

    modport slave (
        input  btn_start_stop, btn_lap_reset, clock_digits,
        output timer_pause, timer_clear, timer_reset, lap_hold, ctrl_state, disp_digits
    );

    modport master (
        output btn_start_stop, btn_lap_reset, clock_digits,
        input  timer_pause, timer_clear, timer_reset, lap_hold, ctrl_state, disp_digits
    );
endinterface

// File: rtl/digital_timer_ctrl.sv
// Two-button timer controller: sync + debounce, five-state FSM, lap snapshot; press to outputs in DEBOUNCE_CYCLES+3 edges.
// No backpressure: each press pulse is consumed or discarded in the cycle it is high.
module digital_timer_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_CYCLES    = 2
) (
    input logic           sys_clk,
    input logic           rst,
    digital_timer_ctrl_if.slave tif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [5:0][6:0] DIGITS_ZERO = {6{7'b0000001}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        CLR   = 3'd4
    } state_t;

    // Index 0 is start/stop, index 1 is lap/reset.
    logic [1:0]    s1, s2, stable, stable_q, press;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            press    <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1       <= {tif.btn_lap_reset, tif.btn_start_stop};
            s2       <= s1;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic ss, lr;
    assign ss = press[0];
    assign lr = press[1];

    state_t        state, state_nxt;
    logic [RW-1:0] rcnt;
    logic          pause_q, clear_q, reset_q, hold_q;
    logic          pause_nxt, clear_nxt, reset_nxt, hold_nxt;
    logic [5:0][6:0] lap_digits, disp_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= IDLE;
            rcnt    <= '0;
            pause_q <= 1'b1;
            clear_q <= 1'b0;
            reset_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rcnt    <= (state == CLR && rcnt != RST_LAST) ? rcnt + 1'b1 : '0;
            pause_q <= pause_nxt;
            clear_q <= clear_nxt;
            reset_q <= reset_nxt;
            hold_q  <= hold_nxt;
        end
    end

    // Start/stop is tested first everywhere so a coincident lap/reset press is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss) state_nxt = RUN;
            RUN:     if (ss) state_nxt = PAUSE; else if (lr) state_nxt = LAP;
            LAP:     if (ss) state_nxt = PAUSE; else if (lr) state_nxt = RUN;
            PAUSE:   if (ss) state_nxt = RUN;   else if (lr) state_nxt = CLR;
            CLR:     if (rcnt == RST_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from the next state so the registered outputs line up with the state register.
    always_comb begin
        pause_nxt = (state_nxt == IDLE) || (state_nxt == PAUSE) || (state_nxt == CLR);
        clear_nxt = (state_nxt == CLR);
        reset_nxt = (state_nxt == CLR);
        hold_nxt  = (state_nxt == LAP);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            lap_digits <= DIGITS_ZERO;
            disp_q     <= DIGITS_ZERO;
        end else begin
            if (state == RUN && state_nxt == LAP) lap_digits <= tif.clock_digits;
            disp_q <= hold_q ? lap_digits : tif.clock_digits;
        end
    end

    assign tif.timer_pause = pause_q;
    assign tif.timer_clear = clear_q;
    assign tif.timer_reset = reset_q;
    assign tif.lap_hold    = hold_q;
    assign tif.ctrl_state  = state;
    assign tif.disp_digits = disp_q;
endmodule

// File: doc/digital_timer_ctrl.md
# digital_timer_ctrl

Two-button controller for the digital timer. It debounces the start/stop and lap/reset buttons and sequences the timer's pause, clear and reset controls through a five-state FSM. It also captures a lap snapshot of the six-digit seven-segment bus and selects the frozen or live value for the display. It sits between the board buttons and the digital timer, on the same `sys_clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synced cycles required to accept a button level change; must be ≥1.
- `RESET_CYCLES`, default 2: number of cycles `timer_reset` is held in CLR; must be ≥1.
- `sys_clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous and active-high.
- `btn_start_stop`  in  1  raw asynchronous start/stop button, active-high.
- `btn_lap_reset`  in  1  raw asynchronous lap/reset button, active-high.
- `clock_digits`  in  [5:0][6:0]  live seven-segment digits from the timer.
- `timer_pause`  out  1  level; holds the timer count.
- `timer_clear`  out  1  level; clears the timer tick counter.
- `timer_reset`  out  1  level; zeroes the timer digits.
- `lap_hold`  out  1  high while the display shows the lap snapshot.
- `ctrl_state`  out  3  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3, CLR=4.
- `disp_digits`  out  [5:0][6:0]  registered display bus.

## Operation
- Button front end, identical for each button:
  - 2-flop synchronizer `s1` → `s2`.
  - Debounce counter `cnt` (width `$clog2(DEBOUNCE_CYCLES+1)`) and accepted level `stable`.
  - Each cycle: if `s2==stable` then `cnt<=0`; else if `cnt==DEBOUNCE_CYCLES-1` then `stable<=s2` and `cnt<=0`; else `cnt<=cnt+1`.
  - Press event is a registered one-cycle pulse, high in the cycle after `stable` goes 0→1.
  - Release (1→0) produces no event.
  - Glitches shorter than `DEBOUNCE_CYCLES` synced cycles produce no change in `stable`.
- FSM transitions (ss = start/stop press, lr = lap/reset press):
  - IDLE: ss→RUN; lr ignored.
  - RUN: ss→PAUSE; lr→LAP, and `lap_digits<=clock_digits` on the same edge.
  - LAP: lr→RUN (snapshot released); ss→PAUSE (`lap_hold` drops).
  - PAUSE: ss→RUN; lr→CLR.
  - CLR: all presses ignored. `rcnt` runs 0..`RESET_CYCLES-1`; on the edge where `rcnt==RESET_CYCLES-1`, go to IDLE with `rcnt<=0`.
- Both press pulses in the same cycle: ss wins and lr is discarded.
- Output decode (Moore, registered, valid from the edge the state is entered):
  - `timer_pause` = 1 in IDLE, PAUSE and CLR; 0 in RUN and LAP.
  - `timer_clear` and `timer_reset` = 1 only in CLR.
  - `lap_hold` = 1 only in LAP.
- Display path: `disp_digits <= lap_hold ? lap_digits : clock_digits`, evaluated every cycle using the current registered `lap_hold`.
- `lap_digits` updates only on the RUN→LAP edge. A second lap requires LAP→RUN→LAP.

## Timing
- Reset values (`rst` sampled high at an edge):
  - state IDLE (`ctrl_state`=0), `timer_pause`=1, `timer_clear`=0, `timer_reset`=0, `lap_hold`=0.
  - `s1`, `s2`, `stable`, `cnt`, `rcnt` and press pulses = 0.
  - `lap_digits` and `disp_digits` = {6{7'b0000001}} (all-zero display).
- `rst` wins over every other event. Asserting it in any state, including mid-CLR, returns to IDLE on that edge.
- A button held through reset is seen as a new press after the debounce interval.
- Press latency, with edge E0 being the first edge sampling raw=1 into `s1`:
  - `s2`=1 at E1.
  - `stable`=1 at E(1+`DEBOUNCE_CYCLES`).
  - Press pulse high after E(2+`DEBOUNCE_CYCLES`).
  - State and outputs change at E(3+`DEBOUNCE_CYCLES`). Default: 7 edges.
- `timer_reset` and `timer_clear` are high for exactly `RESET_CYCLES` cycles.
- `disp_digits` lags its selected source by 1 cycle. On entry to LAP, `disp_digits` shows `lap_digits` one edge after `lap_hold` rises.
- No stall or backpressure; every press pulse is consumed or discarded in its cycle.

## Test plan
- Reset then idle: `rst` for 2 cycles, no buttons → `ctrl_state`=0, `timer_pause`=1, `timer_clear`=`timer_reset`=0, `disp_digits`=all 7'b0000001.
- Clean ss press, `DEBOUNCE_CYCLES`=4 → `ctrl_state`=1 and `timer_pause`=0 exactly 7 edges after the first sampling edge; second ss press → `ctrl_state`=2, `timer_pause`=1.
- Bounce: `btn_start_stop` high for 3 synced cycles, low for 1, repeated 5 times, then held high → only one transition IDLE→RUN, and only after the final 4 consecutive high cycles.
- Lap: in RUN with `clock_digits`=X, lr press → `lap_hold`=1 and `disp_digits`=X next edge, held while `clock_digits` changes; lr again → `lap_hold`=0 and `disp_digits` tracks live digits with 1-cycle lag.
- Clear: RUN → ss (PAUSE) → lr → `ctrl_state`=4 and `timer_reset`=`timer_clear`=1 for exactly 2 cycles, then IDLE; an ss press landing during CLR is ignored.
- Simultaneous ss and lr pulses in the same cycle while in RUN → PAUSE, not LAP; `rst` asserted in CLR cycle 1 → IDLE next edge with `timer_reset`=0.
